irq_service_master: RTL



---
 rtl/irq_pkg.sv | 18 +
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_service_master.sv | 135 +++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt-controller master/responder pair.
// Holds the service FSM states, default register addresses and source count.
package irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STAT,
    ST_DECODE,
    ST_PRESENT,
    ST_WR_ACK,
    ST_TURN
  } irq_state_e;

  localparam logic [15:0] IRQ_STATUS_ADDR = 16'h00EF;
  localparam logic [15:0] IRQ_ACK_ADDR    = 16'h00FF;
  localparam int          IRQ_SRC_N       = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder: index, one-hot mask and any-set flag.
module irq_prio_enc #(
  parameter int W     = 8,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [W-1:0]     mask_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
    mask_o = vec_i & (~vec_i + W'(1));
    any_o  = |vec_i;
  end

endmodule

// File: rtl/irq_service_master.sv
// Bus master that reads the controller's pending status, presents the vector to the core
// and writes a W1C acknowledge. Optional macro SPURIOUS_CNT_EN adds a spurious-read counter.
module irq_service_master
  import irq_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = IRQ_SRC_N,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = IRQ_STATUS_ADDR,
  parameter logic [ADDR_W-1:0] ACK_ADDR    = IRQ_ACK_ADDR,
  parameter int                BUS_WAIT    = 1,
  parameter int                ID_W        = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              irq_i,
  input  logic              enable_i,
  output logic [ADDR_W-1:0] address_o,
  inout  wire  [DATA_W-1:0] data_io,
  output logic              wr_o,
  output logic              rd_o,
  output logic              vec_valid_o,
  output logic [ID_W-1:0]   vec_id_o,
  input  logic              vec_ready_i,
  output logic              busy_o
`ifdef SPURIOUS_CNT_EN
  ,
  output logic [7:0]        spurious_cnt_o
`endif
);

  irq_state_e        state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [ID_W-1:0]   vid_q, vid_d;
  logic [ID_W-1:0]   enc_idx;
  logic [DATA_W-1:0] enc_mask;
  logic              enc_any;
  logic              last_beat;

  irq_prio_enc #(.W(DATA_W), .IDX_W(ID_W)) u_enc (
    .vec_i  (pend_q),
    .idx_o  (enc_idx),
    .mask_o (enc_mask),
    .any_o  (enc_any)
  );

  assign last_beat = (wait_q == 3'(BUS_WAIT));
  // Bus drive is decoded from the registered state so reset releases it asynchronously.
  assign data_io   = wr_o ? mask_q : {DATA_W{1'bz}};
  assign vec_id_o  = vid_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pend_d      = pend_q;
    mask_d      = mask_q;
    vid_d       = vid_q;
    address_o   = '0;
    rd_o        = 1'b0;
    wr_o        = 1'b0;
    vec_valid_o = 1'b0;
    busy_o      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (irq_i && enable_i) begin
          state_d = ST_RD_STAT;
          wait_d  = '0;
        end
      end
      ST_RD_STAT: begin
        address_o = STATUS_ADDR;
        rd_o      = 1'b1;
        if (last_beat) begin
          pend_d  = data_io;
          state_d = ST_DECODE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      ST_DECODE: begin
        if (enc_any) begin
          vid_d   = enc_idx;
          mask_d  = enc_mask;
          state_d = ST_PRESENT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        vec_valid_o = 1'b1;
        if (vec_ready_i) begin
          state_d = ST_WR_ACK;
          wait_d  = '0;
        end
      end
      ST_WR_ACK: begin
        address_o = ACK_ADDR;
        wr_o      = 1'b1;
        if (last_beat) state_d = ST_TURN;
        else           wait_d  = wait_q + 3'd1;
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      vid_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      vid_q   <= vid_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
    mask_q <= mask_d;
  end

`ifdef SPURIOUS_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spurious_cnt_o <= '0;
    end else if (state_q == ST_DECODE && !enc_any && spurious_cnt_o != 8'hFF) begin
      spurious_cnt_o <= spurious_cnt_o + 8'd1;
    end
  end
`endif

endmodule
